// File: rtl/sram_arb_if.sv
// Bus bundle between the two requesters (CPU port A, debug UART port B),
// the arbiter, and the external asynchronous SRAM pins.
// slave = arbiter view, master = requester/SRAM-model view.
interface sram_arb_if;
  // Port A (CPU)
  logic [15:0] a_addr;
  logic        a_r;
  logic [1:0]  a_w;
  logic [15:0] a_wdata;
  logic        a_ack;
  // Port B (debug UART)
  logic [15:0] b_addr;
  logic        b_r;
  logic [1:0]  b_w;
  logic [15:0] b_wdata;
  logic        b_ack;
  // Shared status
  logic [15:0] rdata;
  logic        grant;
  logic        busy;
  // SRAM pins
  logic [14:0] sram_addr;
  logic [15:0] sram_dout;
  logic        sram_den;
  logic [15:0] sram_din;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;
  logic        sram_ub_n;
  logic        sram_lb_n;

  modport slave (
    input  a_addr, a_r, a_w, a_wdata,
    input  b_addr, b_r, b_w, b_wdata,
    input  sram_din,
    output a_ack, b_ack, rdata, grant, busy,
    output sram_addr, sram_dout, sram_den,
    output sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n
  );

  modport master (
    output a_addr, a_r, a_w, a_wdata,
    output b_addr, b_r, b_w, b_wdata,
    output sram_din,
    input  a_ack, b_ack, rdata, grant, busy,
    input  sram_addr, sram_dout, sram_den,
    input  sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n
  );
endinterface

// File: rtl/sram_arb.sv
// Two-port arbiter in front of a 16-bit asynchronous SRAM; IDLE -> ACCESS (WAIT cycles) -> DONE.
// Latency: request seen in IDLE is acked WAIT+1 cycles later; back-to-back accesses take WAIT+2 cycles.
// Backpressure: requesters hold their request until ack; requests are sampled only in IDLE.
// Build option: define SRAM_ARB_ROUND_ROBIN_EN for round-robin arbitration (default: port B fixed priority).
module sram_arb #(
  parameter int unsigned WAIT = 3   // SRAM access cycles per transfer, 2..15
) (
  input  logic       clk,
  input  logic       reset,
  sram_arb_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] WAIT_M1 = 4'(WAIT - 1);
  localparam logic [3:0] WAIT_M2 = 4'(WAIT - 2);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        grant_q;
  logic        busy_q;
  logic        a_ack_q;
  logic        b_ack_q;
  logic        wr_q;
  logic [15:0] rdata_q;
  logic [15:0] dout_q;
  logic [14:0] addr_q;
  logic        den_q;
  logic        ce_n_q;
  logic        oe_n_q;
  logic        we_n_q;
  logic        ub_n_q;
  logic        lb_n_q;

  logic        a_pend;
  logic        b_pend;
  logic        pick_b_d;
  logic [14:0] win_addr_d;
  logic [15:0] win_wdata_d;
  logic [1:0]  win_w_d;
  logic        win_wr_d;

  // WE is held off the first and last ACCESS cycles so address and data
  // surround the write pulse; with only two cycles it goes in the first one.
  // c is the counter value of the ACCESS cycle (WAIT-1 in the first, 0 in the last).
  function automatic logic we_low(input logic [3:0] c);
    if (WAIT == 2) begin
      return (c == 4'd1);
    end
    return (c != 4'd0) && (c <= WAIT_M2);
  endfunction

  // Pick a winner among pending ports and mux its request fields.
  always_comb begin
    a_pend = bus.a_r | (|bus.a_w);
    b_pend = bus.b_r | (|bus.b_w);
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    pick_b_d = b_pend & (~a_pend | ~grant_q);
`else
    pick_b_d = b_pend;
`endif
    win_addr_d  = pick_b_d ? bus.b_addr[15:1] : bus.a_addr[15:1];
    win_wdata_d = pick_b_d ? bus.b_wdata      : bus.a_wdata;
    win_w_d     = pick_b_d ? bus.b_w          : bus.a_w;
    // A write wins over a simultaneous read request.
    win_wr_d    = |win_w_d;
  end

  // Access FSM; all SRAM strobes and handshake outputs are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      grant_q <= 1'b0;
      busy_q  <= 1'b0;
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
      wr_q    <= 1'b0;
      rdata_q <= 16'd0;
      dout_q  <= 16'd0;
      addr_q  <= 15'd0;
      den_q   <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      ub_n_q  <= 1'b1;
      lb_n_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          a_ack_q <= 1'b0;
          b_ack_q <= 1'b0;
          if (a_pend | b_pend) begin
            state_q <= ACCESS;
            cnt_q   <= WAIT_M1;
            grant_q <= pick_b_d;
            busy_q  <= 1'b1;
            wr_q    <= win_wr_d;
            addr_q  <= win_addr_d;
            dout_q  <= win_wdata_d;
            den_q   <= win_wr_d;
            ce_n_q  <= 1'b0;
            oe_n_q  <= win_wr_d;
            we_n_q  <= ~(win_wr_d & we_low(WAIT_M1));
            // Reads fetch the full word; writes use the byte enables.
            ub_n_q  <= win_wr_d & ~win_w_d[1];
            lb_n_q  <= win_wr_d & ~win_w_d[0];
          end
        end
        ACCESS: begin
          if (cnt_q == 4'd0) begin
            state_q <= DONE;
            if (!wr_q) begin
              rdata_q <= bus.sram_din;
            end
            a_ack_q <= ~grant_q;
            b_ack_q <= grant_q;
            den_q   <= 1'b0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            ub_n_q  <= 1'b1;
            lb_n_q  <= 1'b1;
          end else begin
            cnt_q  <= cnt_q - 4'd1;
            we_n_q <= ~(wr_q & we_low(cnt_q - 4'd1));
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          a_ack_q <= 1'b0;
          b_ack_q <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.a_ack     = a_ack_q;
  assign bus.b_ack     = b_ack_q;
  assign bus.rdata     = rdata_q;
  assign bus.grant     = grant_q;
  assign bus.busy      = busy_q;
  assign bus.sram_addr = addr_q;
  assign bus.sram_dout = dout_q;
  assign bus.sram_den  = den_q;
  assign bus.sram_ce_n = ce_n_q;
  assign bus.sram_oe_n = oe_n_q;
  assign bus.sram_we_n = we_n_q;
  assign bus.sram_ub_n = ub_n_q;
  assign bus.sram_lb_n = lb_n_q;

endmodule
